// File: rtl/flush_nibble_serializer_if.sv
// Handshake bundle between the flush FIFO read side, the nibble serializer and the nibble sink.
// The slave modport is the serializer's view; the master modport is the view of the environment driving it.
interface flush_nibble_serializer_if;
   logic        flush_valid_i;
   logic [31:0] flush_data_i;
   logic        flush_ready_o;
   logic        nib_valid_o;
   logic [3:0]  nib_data_o;
   logic        nib_last_o;
   logic        nib_ready_i;

   modport slave (
      input  flush_valid_i, flush_data_i, nib_ready_i,
      output flush_ready_o, nib_valid_o, nib_data_o, nib_last_o
   );

   modport master (
      output flush_valid_i, flush_data_i, nib_ready_i,
      input  flush_ready_o, nib_valid_o, nib_data_o, nib_last_o
   );
endinterface

// File: rtl/flush_nibble_serializer.sv
// Queues 32-bit flush words and replays them one nibble per cycle, stripping PAD_NIBBLE padding.
// Optional feature macro: FLUSH_SER_PARITY_EN adds nib_parity_o (XOR of nib_data_o).
module flush_nibble_serializer #(
   parameter int unsigned DEPTH      = 2,
   parameter logic [3:0]  PAD_NIBBLE = 4'hC,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                       rclock,
   input  logic                       reset,
   flush_nibble_serializer_if.slave   bus_io,
   output logic                       busy_o,
   output logic [CNT_W-1:0]           drop_cnt_o
`ifdef FLUSH_SER_PARITY_EN
   ,
   output logic                       nib_parity_o
`endif
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   logic [31:0]      mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   state_t           state_q;
   logic [31:0]      sr_q;
   logic [2:0]       idx_q;
   logic             nib_valid_q, nib_last_q, nib_parity_q;
   logic [3:0]       nib_data_q;
   logic [CNT_W-1:0] drop_cnt_q;

   logic [31:0]      head_s;
   logic [2:0]       idx_nx_s;
   logic             empty_s, head_ok_s, flush_ready_s, push_s, hs_s, pop_s;

   function automatic logic [3:0] nib_at(input logic [31:0] w, input logic [2:0] k);
      return w[{k, 2'b00} +: 4];
   endfunction

   // A nibble is last at slot 7 or when the following slot holds the pad value.
   function automatic logic last_at(input logic [31:0] w, input logic [2:0] k);
      if (k == 3'd7) begin
         return 1'b1;
      end else begin
         return nib_at(w, k + 3'd1) == PAD_NIBBLE;
      end
   endfunction

   function automatic logic parity4(input logic [3:0] n);
      return ^n;
   endfunction

   assign head_s        = mem_q[rd_ptr_q];
   assign empty_s       = (count_q == {(AW+1){1'b0}});
   assign head_ok_s     = !empty_s && (head_s[3:0] != PAD_NIBBLE);
   assign flush_ready_s = (count_q < DEPTH_C);
   assign push_s        = bus_io.flush_valid_i && flush_ready_s;
   assign hs_s          = nib_valid_q && bus_io.nib_ready_i;
   assign idx_nx_s      = idx_q + 3'd1;

   // Head is consumed when IDLE sees a word, or on a last-nibble handshake with a non-empty head.
   always_comb begin
      pop_s = 1'b0;
      case (state_q)
         IDLE:    pop_s = !empty_s;
         SHIFT:   pop_s = hs_s && nib_last_q && head_ok_s;
         default: pop_s = 1'b0;
      endcase
   end

   // Occupancy follows accepted pushes and pops.
   always_comb begin
      count_d = count_q;
      if (push_s && !pop_s) begin
         count_d = count_q + ONE_C;
      end else if (!push_s && pop_s) begin
         count_d = count_q - ONE_C;
      end else begin
         count_d = count_q;
      end
   end

   // Word storage; stale contents are harmless because the pointers reset.
   always_ff @(posedge rclock) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= bus_io.flush_data_i;
      end
   end

   // Queue pointers, serializer FSM and all registered stream outputs.
   always_ff @(posedge rclock) begin
      if (reset) begin
         wr_ptr_q     <= {AW{1'b0}};
         rd_ptr_q     <= {AW{1'b0}};
         count_q      <= {(AW+1){1'b0}};
         state_q      <= IDLE;
         sr_q         <= 32'h0000_0000;
         idx_q        <= 3'd0;
         nib_valid_q  <= 1'b0;
         nib_data_q   <= 4'h0;
         nib_last_q   <= 1'b0;
         nib_parity_q <= 1'b0;
         drop_cnt_q   <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + ONE_C[AW-1:0];
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + ONE_C[AW-1:0];
         end
         count_q <= count_d;
         case (state_q)
            IDLE: begin
               if (head_ok_s) begin
                  state_q      <= SHIFT;
                  sr_q         <= head_s;
                  idx_q        <= 3'd0;
                  nib_valid_q  <= 1'b1;
                  nib_data_q   <= head_s[3:0];
                  nib_last_q   <= last_at(head_s, 3'd0);
                  nib_parity_q <= parity4(head_s[3:0]);
               end else if (!empty_s && (drop_cnt_q != {CNT_W{1'b1}})) begin
                  drop_cnt_q <= drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            SHIFT: begin
               if (hs_s && !nib_last_q) begin
                  idx_q        <= idx_nx_s;
                  nib_data_q   <= nib_at(sr_q, idx_nx_s);
                  nib_last_q   <= last_at(sr_q, idx_nx_s);
                  nib_parity_q <= parity4(nib_at(sr_q, idx_nx_s));
               end else if (hs_s && head_ok_s) begin
                  // Chain straight into the next word so there is no bubble.
                  sr_q         <= head_s;
                  idx_q        <= 3'd0;
                  nib_data_q   <= head_s[3:0];
                  nib_last_q   <= last_at(head_s, 3'd0);
                  nib_parity_q <= parity4(head_s[3:0]);
               end else if (hs_s) begin
                  state_q      <= IDLE;
                  idx_q        <= 3'd0;
                  nib_valid_q  <= 1'b0;
                  nib_data_q   <= 4'h0;
                  nib_last_q   <= 1'b0;
                  nib_parity_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_io.flush_ready_o = flush_ready_s;
   assign bus_io.nib_valid_o   = nib_valid_q;
   assign bus_io.nib_data_o    = nib_data_q;
   assign bus_io.nib_last_o    = nib_last_q;
   assign busy_o               = !empty_s || (state_q == SHIFT);
   assign drop_cnt_o           = drop_cnt_q;
`ifdef FLUSH_SER_PARITY_EN
   assign nib_parity_o         = nib_parity_q;
`else
   logic unused_parity_s;
   assign unused_parity_s      = nib_parity_q;
`endif

endmodule

// File: tb/tb_flush_nibble_serializer.sv
// Directed self-checking bench for flush_nibble_serializer with hand-computed nibble sequences.
module tb_flush_nibble_serializer;
   logic       rclock;
   logic       rst;
   logic       busy;
   logic [7:0] drop_cnt;
`ifdef FLUSH_SER_PARITY_EN
   logic       nib_parity;
`endif
   int         n_tests;
   int         n_fail;

   flush_nibble_serializer_if ifc ();

   flush_nibble_serializer #(.DEPTH(2), .PAD_NIBBLE(4'hC), .CNT_W(8)) dut (
      .rclock     (rclock),
      .reset      (rst),
      .bus_io     (ifc),
      .busy_o     (busy),
      .drop_cnt_o (drop_cnt)
`ifdef FLUSH_SER_PARITY_EN
      ,
      .nib_parity_o (nib_parity)
`endif
   );

   initial rclock = 1'b0;
   always #5 rclock = ~rclock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge rclock);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      ifc.flush_valid_i = 1'b1;
      ifc.flush_data_i  = w;
      step();
      ifc.flush_valid_i = 1'b0;
   endtask

   // Expects n nibbles of w (oldest first) on consecutive cycles with nib_ready_i high.
   task automatic check_stream(input string tag, input logic [31:0] w, input int n);
      logic [3:0] nib;
      for (int i = 0; i < n; i++) begin
         nib = w[4*i +: 4];
         check({tag, "_valid"}, {31'd0, ifc.nib_valid_o}, 32'd1);
         check({tag, "_data"}, {28'd0, ifc.nib_data_o}, {28'd0, nib});
         check({tag, "_last"}, {31'd0, ifc.nib_last_o}, (i == n - 1) ? 32'd1 : 32'd0);
`ifdef FLUSH_SER_PARITY_EN
         check({tag, "_par"}, {31'd0, nib_parity}, {31'd0, ^nib});
`endif
         step();
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      ifc.flush_valid_i = 1'b0;
      ifc.flush_data_i  = 32'h0;
      ifc.nib_ready_i   = 1'b1;
      step();
      step();
      check("rst_ready", {31'd0, ifc.flush_ready_o}, 32'd1);
      check("rst_valid", {31'd0, ifc.nib_valid_o}, 32'd0);
      check("rst_data", {28'd0, ifc.nib_data_o}, 32'd0);
      check("rst_last", {31'd0, ifc.nib_last_o}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_drop", {24'd0, drop_cnt}, 32'd0);
`ifdef FLUSH_SER_PARITY_EN
      check("rst_par", {31'd0, nib_parity}, 32'd0);
`endif
      rst = 1'b0;
      step();

      // Five-nibble word, first valid one cycle after the push edge.
      push(32'hCCC4_3210);
      check("t1_lat", {31'd0, ifc.nib_valid_o}, 32'd0);
      check("t1_busy", {31'd0, busy}, 32'd1);
      step();
      check_stream("t1", 32'hCCC4_3210, 5);
      check("t1_end", {31'd0, ifc.nib_valid_o}, 32'd0);
      check("t1_drop", {24'd0, drop_cnt}, 32'd0);

      // Full word chained into a one-nibble word with no bubble.
      push(32'h8765_4321);
      push(32'hCCCC_CCC9);
      check_stream("t2a", 32'h8765_4321, 8);
      check_stream("t2b", 32'hCCCC_CCC9, 1);
      check("t2_end", {31'd0, ifc.nib_valid_o}, 32'd0);

      // All-pad word is dropped in one cycle.
      push(32'hCCCC_CCCC);
      check("t3_busy1", {31'd0, busy}, 32'd1);
      check("t3_valid1", {31'd0, ifc.nib_valid_o}, 32'd0);
      step();
      check("t3_busy2", {31'd0, busy}, 32'd0);
      check("t3_drop", {24'd0, drop_cnt}, 32'd1);
      check("t3_valid2", {31'd0, ifc.nib_valid_o}, 32'd0);
      step();
      check("t3_valid3", {31'd0, ifc.nib_valid_o}, 32'd0);

      // Stall with data held stable.
      ifc.nib_ready_i = 1'b0;
      push(32'hCCCC_CBA5);
      step();
      for (int i = 0; i < 3; i++) begin
         check("t4_hold_v", {31'd0, ifc.nib_valid_o}, 32'd1);
         check("t4_hold_d", {28'd0, ifc.nib_data_o}, 32'h5);
         check("t4_hold_l", {31'd0, ifc.nib_last_o}, 32'd0);
         step();
      end
      ifc.nib_ready_i = 1'b1;
      check_stream("t4", 32'hCCCC_CBA5, 3);
      check("t4_end", {31'd0, ifc.nib_valid_o}, 32'd0);

      // Fill serializer and queue; a fourth word offered while full is lost.
      ifc.nib_ready_i = 1'b0;
      push(32'hCCCC_CC21);
      push(32'hCCCC_C654);
      check("t5_rdy_mid", {31'd0, ifc.flush_ready_o}, 32'd1);
      push(32'hCCCC_CC87);
      check("t5_rdy_full", {31'd0, ifc.flush_ready_o}, 32'd0);
      ifc.flush_valid_i = 1'b1;
      ifc.flush_data_i  = 32'h0000_00EF;
      step();
      step();
      ifc.flush_valid_i = 1'b0;
      check("t5_busy", {31'd0, busy}, 32'd1);
      ifc.nib_ready_i = 1'b1;
      check_stream("t5a", 32'hCCCC_CC21, 2);
      check_stream("t5b", 32'hCCCC_C654, 3);
      check_stream("t5c", 32'hCCCC_CC87, 2);
      for (int i = 0; i < 4; i++) begin
         check("t5_no4th", {31'd0, ifc.nib_valid_o}, 32'd0);
         step();
      end
      check("t5_idle_busy", {31'd0, busy}, 32'd0);

      // Reset after two of eight nibbles were accepted.
      push(32'h8765_4321);
      step();
      step();
      step();
      check("t6_pre_data", {28'd0, ifc.nib_data_o}, 32'h3);
      rst = 1'b1;
      step();
      check("t6_valid", {31'd0, ifc.nib_valid_o}, 32'd0);
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_drop", {24'd0, drop_cnt}, 32'd0);
      check("t6_ready", {31'd0, ifc.flush_ready_o}, 32'd1);
      rst = 1'b0;
      step();
      check("t6_quiet", {31'd0, ifc.nib_valid_o}, 32'd0);
      push(32'hCCCC_C9AB);
      step();
      check_stream("t6", 32'hCCCC_C9AB, 3);
      check("t6_end", {31'd0, ifc.nib_valid_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
